// File: rtl/laser_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : laser_tx_scheduler
// Description : Frames a host byte stream into packets for the two-channel
//               laser transmitter: sync pair, alternating payload pairs,
//               per-channel XOR checksum pair, then an idle gap. Stalled
//               payloads are padded with zero bytes after a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_tx_scheduler #(
    parameter int         PAYLOAD_PAIRS = 32,
    parameter logic [7:0] SYNC1         = 8'hA5,
    parameter logic [7:0] SYNC2         = 8'h5A,
    parameter int         GAP_CYCLES    = 16,
    parameter int         STALL_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  host_data,
    input  logic        host_valid,
    output logic        host_ready,
    output logic [7:0]  tx_data1,
    output logic [7:0]  tx_data2,
    output logic        tx_ready1,
    output logic        tx_ready2,
    output logic        tx_en,
    input  logic        tx_done,
    output logic        busy,
    output logic        pad_event,
    output logic [15:0] pkt_count
);

    localparam int PW = $clog2(PAYLOAD_PAIRS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int SW = $clog2(STALL_TIMEOUT + 1);

    localparam logic [PW-1:0] c_LAST_PAIR  = PW'(PAYLOAD_PAIRS - 1);
    localparam logic [GW-1:0] c_GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [SW-1:0] c_STALL_LAST = SW'(STALL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HEADER   = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_CHECKSUM = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t          state_q,    state_d;
    logic [7:0]      lo_q,       lo_d;
    logic [7:0]      hi_q,       hi_d;
    logic            lo_full_q,  lo_full_d;
    logic            hi_full_q,  hi_full_d;
    logic [7:0]      chk1_q,     chk1_d;
    logic [7:0]      chk2_q,     chk2_d;
    logic [PW-1:0]   pair_idx_q, pair_idx_d;
    logic [SW-1:0]   stall_q,    stall_d;
    logic [GW-1:0]   gap_q,      gap_d;
    logic            pad_mode_q, pad_mode_d;
    logic            pad_evt_q,  pad_evt_d;
    logic [15:0]     pkt_q,      pkt_d;
    logic [7:0]      txd1_q,     txd1_d;
    logic [7:0]      txd2_q,     txd2_d;
    logic            txr_q,      txr_d;

    logic w_full;
    logic w_host_ready;
    logic w_accept;
    logic w_fire;

    assign w_full   = lo_full_q & hi_full_q;
    assign w_accept = host_valid & w_host_ready;
    // A handshake only counts while a pair is presented and the block is running.
    assign w_fire   = tx_done & txr_q & en;

    // Host back-pressure: open in IDLE, prefetch while a slot is free, closed when padding.
    always_comb begin
        w_host_ready = 1'b0;
        if (!reset && en) begin
            case (state_q)
                S_IDLE:    w_host_ready = 1'b1;
                S_HEADER:  w_host_ready = ~w_full;
                S_PAYLOAD: w_host_ready = ~w_full & ~pad_mode_q;
                default:   w_host_ready = 1'b0;
            endcase
        end
    end

    // Next-state logic for the framer; everything holds while en is low.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        lo_full_d  = lo_full_q;
        hi_full_d  = hi_full_q;
        chk1_d     = chk1_q;
        chk2_d     = chk2_q;
        pair_idx_d = pair_idx_q;
        stall_d    = stall_q;
        gap_d      = gap_q;
        pad_mode_d = pad_mode_q;
        pad_evt_d  = 1'b0;
        pkt_d      = pkt_q;
        txd1_d     = txd1_q;
        txd2_d     = txd2_q;
        txr_d      = txr_q;

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    stall_d = '0;
                    if (w_accept) begin
                        lo_d       = host_data;
                        lo_full_d  = 1'b1;
                        hi_full_d  = 1'b0;
                        chk1_d     = 8'h00;
                        chk2_d     = 8'h00;
                        pad_mode_d = 1'b0;
                        state_d    = S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (w_accept) begin
                        if (!lo_full_q) begin
                            lo_d      = host_data;
                            lo_full_d = 1'b1;
                        end else begin
                            hi_d      = host_data;
                            hi_full_d = 1'b1;
                        end
                    end
                    if (w_fire) begin
                        state_d    = S_PAYLOAD;
                        pair_idx_d = '0;
                    end
                end
                S_PAYLOAD: begin
                    if (w_fire) begin
                        chk1_d     = chk1_q ^ lo_q;
                        chk2_d     = chk2_q ^ hi_q;
                        pair_idx_d = pair_idx_q + 1'b1;
                        if (pair_idx_q == c_LAST_PAIR) begin
                            state_d    = S_CHECKSUM;
                            lo_full_d  = 1'b0;
                            hi_full_d  = 1'b0;
                            pad_mode_d = 1'b0;
                            stall_d    = '0;
                        end else if (pad_mode_q) begin
                            // Padding presents the next zero pair without waiting.
                            lo_d      = 8'h00;
                            hi_d      = 8'h00;
                            lo_full_d = 1'b1;
                            hi_full_d = 1'b1;
                        end else begin
                            lo_full_d = 1'b0;
                            hi_full_d = 1'b0;
                        end
                    end else if (w_accept) begin
                        stall_d = '0;
                        if (!lo_full_q) begin
                            lo_d      = host_data;
                            lo_full_d = 1'b1;
                        end else begin
                            hi_d      = host_data;
                            hi_full_d = 1'b1;
                        end
                    end else if (!w_full) begin
                        stall_d = stall_q + 1'b1;
                        if (stall_q == c_STALL_LAST) begin
                            if (!lo_full_q) lo_d = 8'h00;
                            if (!hi_full_q) hi_d = 8'h00;
                            lo_full_d  = 1'b1;
                            hi_full_d  = 1'b1;
                            pad_mode_d = 1'b1;
                            pad_evt_d  = 1'b1;
                        end
                    end
                end
                S_CHECKSUM: begin
                    if (w_fire) begin
                        pkt_d   = pkt_q + 16'd1;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == c_GAP_LAST) begin
                        state_d = S_IDLE;
                        stall_d = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Registered transmitter outputs follow the state being entered.
            case (state_d)
                S_HEADER: begin
                    txd1_d = SYNC1;
                    txd2_d = SYNC2;
                    txr_d  = 1'b1;
                end
                S_PAYLOAD: begin
                    txr_d = lo_full_d & hi_full_d;
                    if (lo_full_d && hi_full_d) begin
                        txd1_d = lo_d;
                        txd2_d = hi_d;
                    end
                end
                S_CHECKSUM: begin
                    txd1_d = chk1_d;
                    txd2_d = chk2_d;
                    txr_d  = 1'b1;
                end
                default: txr_d = 1'b0;
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            lo_full_q  <= 1'b0;
            hi_full_q  <= 1'b0;
            chk1_q     <= 8'h00;
            chk2_q     <= 8'h00;
            pair_idx_q <= '0;
            stall_q    <= '0;
            gap_q      <= '0;
            pad_mode_q <= 1'b0;
            pad_evt_q  <= 1'b0;
            pkt_q      <= 16'h0000;
            txd1_q     <= 8'h00;
            txd2_q     <= 8'h00;
            txr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            lo_full_q  <= lo_full_d;
            hi_full_q  <= hi_full_d;
            chk1_q     <= chk1_d;
            chk2_q     <= chk2_d;
            pair_idx_q <= pair_idx_d;
            stall_q    <= stall_d;
            gap_q      <= gap_d;
            pad_mode_q <= pad_mode_d;
            pad_evt_q  <= pad_evt_d;
            pkt_q      <= pkt_d;
            txd1_q     <= txd1_d;
            txd2_q     <= txd2_d;
            txr_q      <= txr_d;
        end
    end

    assign host_ready = w_host_ready;
    assign tx_data1   = txd1_q;
    assign tx_data2   = txd2_q;
    assign tx_ready1  = txr_q;
    assign tx_ready2  = txr_q;
    assign tx_en      = en & ~reset;
    assign busy       = (state_q != S_IDLE);
    assign pad_event  = pad_evt_q;
    assign pkt_count  = pkt_q;

endmodule
`default_nettype wire
